// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: table entry layout,
// sequencer state encoding and the status code reported on timeout.
package i2c_seq_pkg;

    localparam int unsigned ENTRY_W  = 33;
    localparam int unsigned LAST_BIT = 32;
    localparam int unsigned RD_BIT   = 31;
    localparam int unsigned CHIP_HI  = 30;
    localparam int unsigned CHIP_LO  = 24;
    localparam int unsigned REG_HI   = 23;
    localparam int unsigned REG_LO   = 16;
    localparam int unsigned DATA_HI  = 15;
    localparam int unsigned DATA_LO  = 0;

    localparam logic [4:0] STATUS_TIMEOUT = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } seq_state_e;

endpackage

// File: rtl/i2c_seq_loader.sv
// Replays a table of I2C register writes/reads into i2c_master, retrying
// failed entries, timing out stuck transfers and streaming readback data.
module i2c_seq_loader
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TBL_AW    = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned TO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [TBL_AW-1:0] err_index,
    output logic [4:0]        err_status,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_data,
    output logic [6:0]        m_chip_addr,
    output logic [7:0]        m_reg_addr,
    output logic [15:0]       m_datai,
    output logic              m_we,
    output logic              m_re,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [4:0]        m_status,
    input  logic [15:0]       m_datao,
    output logic              rd_valid,
    output logic [TBL_AW-1:0] rd_index,
    output logic [15:0]       rd_data
);

    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TBL_AW-1:0] LAST_IDX = '1;

    seq_state_e        r_state, w_state_n;
    logic [TBL_AW-1:0] r_index, w_index_n;
    logic [RTY_W-1:0]  r_retry, w_retry_n;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_n;
    logic              r_rd, w_rd_n;
    logic              r_last, w_last_n;
    logic              r_abort_req, w_abort_req_n;
    logic [4:0]        r_status, w_status_n;
    logic [15:0]       r_datao, w_datao_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              r_error, w_error_n;
    logic              r_aborted, w_aborted_n;
    logic [TBL_AW-1:0] r_err_index, w_err_index_n;
    logic [4:0]        r_err_status, w_err_status_n;
    logic [6:0]        r_chip, w_chip_n;
    logic [7:0]        r_reg, w_reg_n;
    logic [15:0]       r_data, w_data_n;
    logic              r_we, w_we_n;
    logic              r_re, w_re_n;
    logic              r_rd_valid, w_rd_valid_n;
    logic [TBL_AW-1:0] r_rd_index, w_rd_index_n;
    logic [15:0]       r_rd_data, w_rd_data_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_retry      <= '0;
            r_to_cnt     <= '0;
            r_rd         <= 1'b0;
            r_last       <= 1'b0;
            r_abort_req  <= 1'b0;
            r_status     <= '0;
            r_datao      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
            r_err_index  <= '0;
            r_err_status <= '0;
            r_chip       <= '0;
            r_reg        <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_index   <= '0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_index      <= w_index_n;
            r_retry      <= w_retry_n;
            r_to_cnt     <= w_to_cnt_n;
            r_rd         <= w_rd_n;
            r_last       <= w_last_n;
            r_abort_req  <= w_abort_req_n;
            r_status     <= w_status_n;
            r_datao      <= w_datao_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_error      <= w_error_n;
            r_aborted    <= w_aborted_n;
            r_err_index  <= w_err_index_n;
            r_err_status <= w_err_status_n;
            r_chip       <= w_chip_n;
            r_reg        <= w_reg_n;
            r_data       <= w_data_n;
            r_we         <= w_we_n;
            r_re         <= w_re_n;
            r_rd_valid   <= w_rd_valid_n;
            r_rd_index   <= w_rd_index_n;
            r_rd_data    <= w_rd_data_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_index_n      = r_index;
        w_retry_n      = r_retry;
        w_to_cnt_n     = r_to_cnt;
        w_rd_n         = r_rd;
        w_last_n       = r_last;
        w_status_n     = r_status;
        w_datao_n      = r_datao;
        w_busy_n       = r_busy;
        w_error_n      = r_error;
        w_aborted_n    = r_aborted;
        w_err_index_n  = r_err_index;
        w_err_status_n = r_err_status;
        w_chip_n       = r_chip;
        w_reg_n        = r_reg;
        w_data_n       = r_data;
        w_rd_index_n   = r_rd_index;
        w_rd_data_n    = r_rd_data;
        w_we_n         = 1'b0;
        w_re_n         = 1'b0;
        w_rd_valid_n   = 1'b0;
        // Abort is only remembered while a sequence is running
        w_abort_req_n  = r_abort_req | (r_busy & abort);

        unique case (r_state)
            S_IDLE: begin
                if (start && !m_busy) begin
                    w_busy_n       = 1'b1;
                    w_error_n      = 1'b0;
                    w_aborted_n    = 1'b0;
                    w_err_index_n  = '0;
                    w_err_status_n = '0;
                    w_index_n      = '0;
                    w_abort_req_n  = 1'b0;
                    w_state_n      = S_FETCH;
                end
            end
            S_FETCH: w_state_n = S_LATCH;
            S_LATCH: begin
                w_chip_n  = tbl_data[CHIP_HI:CHIP_LO];
                w_reg_n   = tbl_data[REG_HI:REG_LO];
                w_data_n  = tbl_data[DATA_HI:DATA_LO];
                w_rd_n    = tbl_data[RD_BIT];
                w_last_n  = tbl_data[LAST_BIT];
                w_retry_n = '0;
                w_state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    w_we_n     = ~r_rd;
                    w_re_n     = r_rd;
                    w_to_cnt_n = '0;
                    w_state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    w_status_n = m_status;
                    w_datao_n  = m_datao;
                    w_state_n  = S_CHECK;
                end else if (r_to_cnt == TO_W'(TIMEOUT)) begin
                    w_error_n      = 1'b1;
                    w_err_status_n = STATUS_TIMEOUT;
                    w_err_index_n  = r_index;
                    w_state_n      = S_FINISH;
                end else begin
                    w_to_cnt_n = r_to_cnt + TO_W'(1);
                end
            end
            S_CHECK: begin
                if (r_status == 5'd0) begin
                    if (r_rd) begin
                        w_rd_valid_n = 1'b1;
                        w_rd_index_n = r_index;
                        w_rd_data_n  = r_datao;
                    end
                    if (r_last || (r_index == LAST_IDX)) begin
                        w_state_n = S_FINISH;
                    end else if (r_abort_req) begin
                        w_aborted_n = 1'b1;
                        w_state_n   = S_FINISH;
                    end else begin
                        w_index_n = r_index + TBL_AW'(1);
                        w_state_n = S_FETCH;
                    end
                end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                    w_retry_n = r_retry + RTY_W'(1);
                    w_state_n = S_ISSUE;
                end else begin
                    w_error_n      = 1'b1;
                    w_err_status_n = r_status;
                    w_err_index_n  = r_index;
                    w_state_n      = S_FINISH;
                end
            end
            S_FINISH: begin
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase

        // FINISH lasts exactly one cycle, so this yields a single done pulse
        w_done_n = (w_state_n == S_FINISH);
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign aborted     = r_aborted;
    assign err_index   = r_err_index;
    assign err_status  = r_err_status;
    assign tbl_addr    = r_index;
    assign m_chip_addr = r_chip;
    assign m_reg_addr  = r_reg;
    assign m_datai     = r_data;
    assign m_we        = r_we;
    assign m_re        = r_re;
    assign rd_valid    = r_rd_valid;
    assign rd_index    = r_rd_index;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_i2c_seq_loader.sv
// Directed bench for i2c_seq_loader with a behavioural table memory and a
// simple i2c_master/slave model (slave at 0x70, NACK elsewhere).
module tb_i2c_seq_loader;

    localparam int unsigned TBL_AW    = 4;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 100;
    localparam int unsigned TO_W      = 16;
    localparam logic [4:0]  NACK      = 5'h02;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, error, aborted;
    logic [TBL_AW-1:0] err_index, tbl_addr, rd_index;
    logic [4:0]        err_status;
    logic [32:0]       tbl_data;
    logic [6:0]        m_chip_addr;
    logic [7:0]        m_reg_addr;
    logic [15:0]       m_datai, m_datao, rd_data;
    logic              m_we, m_re, m_busy, m_done, rd_valid;
    logic [4:0]        m_status;

    always #5 clk = ~clk;

    i2c_seq_loader #(
        .TBL_AW(TBL_AW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .aborted(aborted),
        .err_index(err_index), .err_status(err_status),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_datai(m_datai),
        .m_we(m_we), .m_re(m_re), .m_busy(m_busy), .m_done(m_done),
        .m_status(m_status), .m_datao(m_datao),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_data(rd_data)
    );

    logic [32:0] tbl [16];
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // Master + slave model: 4-cycle transfer, register file behind chip 0x70
    logic [15:0] smem [256];
    logic [3:0]  mcnt;
    logic        mstall = 1'b0;
    logic        op_rd;
    logic [6:0]  op_chip;
    logic [7:0]  op_reg;
    logic [15:0] op_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_status <= 5'd0;
            m_datao  <= 16'd0;
            mcnt     <= 4'd0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && (m_we || m_re)) begin
                m_busy  <= 1'b1;
                mcnt    <= 4'd3;
                op_rd   <= m_re;
                op_chip <= m_chip_addr;
                op_reg  <= m_reg_addr;
                op_data <= m_datai;
            end else if (m_busy && !mstall) begin
                if (mcnt == 4'd0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    if (op_chip != 7'h70) begin
                        m_status <= NACK;
                        m_datao  <= 16'd0;
                    end else begin
                        m_status <= 5'd0;
                        if (op_rd) m_datao <= smem[op_reg];
                        else       smem[op_reg] <= op_data;
                    end
                end else begin
                    mcnt <= mcnt - 4'd1;
                end
            end
        end
    end

    int          we_cnt = 0, re_cnt = 0, rd_cnt = 0;
    logic [7:0]  last_reg = 8'd0;
    logic [3:0]  rd_idx_s = 4'd0;
    logic [15:0] rd_data_s = 16'd0;

    always @(posedge clk) begin
        if (m_we) begin
            we_cnt   <= we_cnt + 1;
            last_reg <= m_reg_addr;
        end
        if (m_re) begin
            re_cnt   <= re_cnt + 1;
            last_reg <= m_reg_addr;
        end
        if (rd_valid) begin
            rd_cnt    <= rd_cnt + 1;
            rd_idx_s  <= rd_index;
            rd_data_s <= rd_data;
        end
    end

    int checks = 0;
    int errors = 0;
    int b_we, b_re, b_rd, ncyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [7:0] reg_a);
        int n;
        n = 0;
        while (!((m_we === 1'b1 || m_re === 1'b1) && m_reg_addr === reg_a) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(m_we | m_re), 32'd1);
    endtask

    task automatic snap();
        b_we = we_cnt;
        b_re = re_cnt;
        b_rd = rd_cnt;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) tbl[i] = 33'd0;
    endtask

    initial begin
        clear_tbl();
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_we", 32'(m_we), 32'd0);
        chk("reset_tbl_addr", 32'(tbl_addr), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write then read back through the slave
        tbl[0] = {1'b0, 1'b0, 7'h70, 8'h55, 16'hAAC3};
        tbl[1] = {1'b1, 1'b1, 7'h70, 8'h55, 16'h0000};
        snap();
        pulse_start(1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", ncyc);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_tbl_addr", 32'(tbl_addr), 32'd1);
        @(negedge clk);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_we_cnt", 32'(we_cnt - b_we), 32'd1);
        chk("t1_re_cnt", 32'(re_cnt - b_re), 32'd1);
        chk("t1_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);
        chk("t1_rd_index", 32'(rd_idx_s), 32'd1);
        chk("t1_rd_data", 32'(rd_data_s), 32'hAAC3);

        // Unacknowledged chip: initial try plus three retries
        clear_tbl();
        tbl[0] = {1'b1, 1'b0, 7'h71, 8'h10, 16'h1234};
        snap();
        pulse_start(1'b0);
        wait_done("t2_done", ncyc);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_err_index", 32'(err_index), 32'd0);
        chk("t2_err_status", 32'(err_status), 32'(NACK));
        chk("t2_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        chk("t2_we_cnt", 32'(we_cnt - b_we), 32'd4);

        // Master that never finishes: timeout 101 cycles after the request
        tbl[0] = {1'b1, 1'b0, 7'h70, 8'h66, 16'h0001};
        mstall = 1'b1;
        pulse_start(1'b0);
        chk("t3_error_cleared", 32'(error), 32'd0);
        wait_req("t3_we", 8'h66);
        wait_done("t3_done", ncyc);
        chk("t3_latency", 32'(ncyc), 32'd101);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_err_status", 32'(err_status), 32'h1F);
        chk("t3_err_index", 32'(err_index), 32'd0);
        mstall = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full table with no last marker stops at the final entry
        for (int i = 0; i < 16; i++) tbl[i] = {1'b0, 1'b0, 7'h70, 8'(i), 16'(i)};
        snap();
        pulse_start(1'b0);
        wait_done("t4_done", ncyc);
        chk("t4_tbl_addr", 32'(tbl_addr), 32'd15);
        chk("t4_error", 32'(error), 32'd0);
        @(negedge clk);
        chk("t4_we_cnt", 32'(we_cnt - b_we), 32'd16);
        chk("t4_last_reg", 32'(last_reg), 32'h0F);
        repeat (5) @(negedge clk);
        chk("t4_no_more", 32'(we_cnt - b_we), 32'd16);

        // Abort during entry 1 lets it complete, then stops
        clear_tbl();
        for (int i = 0; i < 4; i++) tbl[i] = {1'b0, 1'b0, 7'h70, 8'(32 + i), 16'(i)};
        tbl[3][32] = 1'b1;
        snap();
        pulse_start(1'b0);
        wait_req("t5_entry1", 8'h21);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t5_done", ncyc);
        chk("t5_aborted", 32'(aborted), 32'd1);
        chk("t5_error", 32'(error), 32'd0);
        @(negedge clk);
        chk("t5_we_cnt", 32'(we_cnt - b_we), 32'd2);
        chk("t5_last_reg", 32'(last_reg), 32'h21);

        // Reset in the middle of a transfer, then a clean rerun
        clear_tbl();
        tbl[0] = {1'b0, 1'b0, 7'h70, 8'h55, 16'hAAC3};
        tbl[1] = {1'b1, 1'b1, 7'h70, 8'h55, 16'h0000};
        pulse_start(1'b0);
        wait_req("t6_we", 8'h55);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_we", 32'(m_we), 32'd0);
        chk("t6_re", 32'(m_re), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        snap();
        pulse_start(1'b1);
        wait_done("t6_rerun_done", ncyc);
        chk("t6_aborted", 32'(aborted), 32'd0);
        chk("t6_error", 32'(error), 32'd0);
        @(negedge clk);
        chk("t6_we_cnt", 32'(we_cnt - b_we), 32'd1);
        chk("t6_re_cnt", 32'(re_cnt - b_re), 32'd1);
        chk("t6_rd_data", 32'(rd_data_s), 32'hAAC3);
        chk("t6_rd_index", 32'(rd_idx_s), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
